// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner FSM states, hex keymap and small decode helper
// Ports: none (package)
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;
  // KEYMAP[row][col]; row 0 = {A,3,2,1} read col3..col0
  localparam logic [3:0][3:0][3:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [1:0] low_col(input logic [3:0] c);
    return c[0] ? 2'd0 : c[1] ? 2'd1 : c[2] ? 2'd2 : c[3] ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/keypad_scanner_sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs
// Ports: clk, reset (sync, active-high), d_i async input, q_o synchronized output (2-cycle latency)
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix row scanner with debounce, one key_valid strobe per press
// Ports: clk, reset (sync, active-high), cols async active-high columns, rows one-hot row drive,
//        key_valid one-cycle press strobe, key_code last accepted hex code, key_held key still down
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 2000,
  parameter int DB_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);
  if (SCAN_DIV < 3 || DB_CYCLES < 2) begin : g_param_check
    $error("keypad_scanner: SCAN_DIV must be >= 3 and DB_CYCLES >= 2");
  end
  logic [3:0] cols_s;
  state_e state_q, state_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [DW-1:0] db_q, db_d;
  logic [3:0] rows_q, code_q, code_d;
  logic valid_q, valid_d, held_q, held_d;
  sync2 #(.W(4)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (cols),
    .q_o  (cols_s)
  );
  // Only the captured column matters once a key is latched; rows stay frozen until SCAN resumes
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    scan_d  = scan_q;
    db_d    = db_q;
    valid_d = 1'b0;
    code_d  = code_q;
    held_d  = held_q;
    unique case (state_q)
      SCAN: begin
        scan_d = scan_q == SCAN_MAX ? '0 : scan_q + 1'b1;
        if (scan_q == SCAN_MAX) begin
          row_d   = cols_s == '0 ? row_q + 2'd1 : row_q;
          col_d   = cols_s == '0 ? col_q : low_col(cols_s);
          db_d    = '0;
          state_d = cols_s == '0 ? SCAN : DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!cols_s[col_q]) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          scan_d  = '0;
        end else if (db_q == DB_MAX) begin
          state_d = HELD;
          valid_d = 1'b1;
          code_d  = KEYMAP[row_q][col_q];
          held_d  = 1'b1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      HELD: begin
        state_d = cols_s[col_q] ? HELD : RELEASE;
        db_d    = '0;
      end
      RELEASE: begin
        if (cols_s[col_q]) begin
          db_d = '0;
        end else if (db_q == DB_MAX) begin
          state_d = SCAN;
          held_d  = 1'b0;
          row_d   = row_q + 2'd1;
          scan_d  = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      row_q   <= '0;
      rows_q  <= 4'b0001;
      col_q   <= '0;
      scan_q  <= '0;
      db_q    <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rows_q  <= 4'b0001 << row_d;
      col_q   <= col_d;
      scan_q  <= scan_d;
      db_q    <= db_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      held_q  <= held_d;
    end
  end
  assign rows      = rows_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench driving a 4x4 key matrix model into keypad_scanner
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] cols, rows, key_code;
  logic key_valid, key_held;
  logic [15:0] closed;
  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  keypad_scanner #(.SCAN_DIV(4), .DB_CYCLES(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .cols     (cols),
    .rows     (rows),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );
  always_comb begin
    cols = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (closed[r*4+c] && rows[r]) cols[c] = 1'b1;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (key_valid) begin
        check("strobe_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("key_code", key_code, e);
          check("held_at_strobe", key_held, 1);
        end
      end
    end
  end
  task automatic wait_row_start(input logic [3:0] r);
    logic [3:0] prev;
    int n;
    prev = rows;
    n = 0;
    @(negedge clk);
    while (!(rows == r && prev != r) && n < 100) begin
      prev = rows;
      @(negedge clk);
      n++;
    end
    check("row_reached", rows, r);
  endtask
  task automatic wait_held_low(input int bound);
    int n;
    n = 0;
    while (key_held && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("held_fall", key_held, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    closed = '0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_rows", rows, 4'b0001);
      check("rst_valid", key_valid, 0);
      check("rst_code", key_code, 0);
      check("rst_held", key_held, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("rotate", rows, 32'(1) << ((i + 1) / 4));
    end
    @(negedge clk);
    closed[1*4+2] = 1'b1;
    exp_q.push_back(4'h6);
    repeat (60) @(negedge clk);
    check("r1c2_frozen", rows, 4'b0010);
    check("r1c2_held", key_held, 1);
    closed = '0;
    repeat (8) @(posedge clk);
    #1;
    check("r1c2_held_debounce", key_held, 1);
    wait_held_low(4);
    check("r1c2_missing", exp_q.size(), 0);
    wait_row_start(4'b0100);
    closed[2*4+0] = 1'b1;
    repeat (3) @(negedge clk);
    closed = '0;
    repeat (2) @(posedge clk);
    #1;
    check("short_capture", rows, 4'b0100);
    @(posedge clk);
    #1;
    check("short_resume", rows, 4'b1000);
    repeat (20) @(negedge clk);
    check("short_no_strobe", exp_q.size(), 0);
    @(negedge clk);
    closed[0] = 1'b1;
    exp_q.push_back(4'h1);
    repeat (40) @(negedge clk);
    closed[1*4+1] = 1'b1;
    repeat (20) @(negedge clk);
    check("r0c0_frozen", rows, 4'b0001);
    check("r0c0_held", key_held, 1);
    closed = '0;
    repeat (8) @(posedge clk);
    #1;
    wait_held_low(4);
    check("code_holds", key_code, 4'h1);
    repeat (5) @(negedge clk);
    closed[1*4+1] = 1'b1;
    exp_q.push_back(4'h5);
    repeat (40) @(negedge clk);
    closed = '0;
    repeat (20) @(negedge clk);
    check("two_key_missing", exp_q.size(), 0);
    wait_row_start(4'b1000);
    closed[3*4+1] = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    closed = '0;
    @(posedge clk);
    #1;
    check("abort_rows", rows, 4'b0001);
    check("abort_held", key_held, 0);
    check("abort_valid", key_valid, 0);
    check("abort_code", key_code, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_strobe", exp_q.size(), 0);
    closed[3*4+3] = 1'b1;
    exp_q.push_back(4'hD);
    repeat (40) @(negedge clk);
    check("r3c3_held", key_held, 1);
    closed = '0;
    repeat (3) @(negedge clk);
    closed[3*4+3] = 1'b1;
    @(negedge clk);
    closed = '0;
    repeat (3) @(negedge clk);
    closed[3*4+3] = 1'b1;
    @(negedge clk);
    closed = '0;
    repeat (8) @(posedge clk);
    #1;
    check("bounce_held", key_held, 1);
    wait_held_low(4);
    repeat (20) @(negedge clk);
    check("bounce_missing", exp_q.size(), 0);
    check("bounce_code", key_code, 4'hD);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
